// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake bundle for seq_restoring_divider: request operands in, results and status out.
interface seq_restoring_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro DIVIDER_DBZ_FASTPATH_EN: a zero divisor completes in one cycle and raises div_by_zero.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_restoring_divider_if.slave dif
);
    localparam int unsigned AW    = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef DIVIDER_DBZ_FASTPATH_EN
    localparam bit FASTPATH = 1'b1;
`else
    localparam bit FASTPATH = 1'b0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [AW+WIDTH-1:0] aq_sh_c;
    logic [AW-1:0]       a_sh_c;
    logic [WIDTH-1:0]    q_sh_c;
    logic [AW-1:0]       diff_c;
    logic [AW-1:0]       a_step_c;
    logic [WIDTH-1:0]    q_step_c;

    // One restoring iteration: shift {A,Q}, trial-subtract M, keep or restore.
    always_comb begin
        aq_sh_c = {a_q, q_q} << 1;
        a_sh_c  = aq_sh_c[AW+WIDTH-1:WIDTH];
        q_sh_c  = aq_sh_c[WIDTH-1:0];
        diff_c  = a_sh_c - {1'b0, m_q};
        if (diff_c[WIDTH]) begin
            a_step_c = a_sh_c;
            q_step_c = q_sh_c;
        end else begin
            a_step_c = diff_c;
            q_step_c = q_sh_c | WIDTH'(1);
        end
    end

    // Next-state and register updates; done is a one-cycle pulse by default.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (dif.start) begin
                    if (FASTPATH && (dif.divisor == '0)) begin
                        quot_d = '1;
                        rem_d  = dif.dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        m_d     = dif.divisor;
                        q_d     = dif.dividend;
                        a_d     = '0;
                        count_d = CNT_W'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                a_d     = a_step_c;
                q_d     = q_step_c;
                count_d = count_q - CNT_W'(1);
                // Final iteration publishes results straight from the step logic.
                if (count_q == CNT_W'(1)) begin
                    quot_d  = q_step_c;
                    rem_d   = a_step_c[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign dif.busy        = busy_q;
    assign dif.done        = done_q;
    assign dif.quotient    = quot_q;
    assign dif.remainder   = rem_q;
    assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8) with a scoreboard of expected results.
module tb_seq_restoring_divider;
    localparam int unsigned WIDTH = 8;
`ifdef DIVIDER_DBZ_FASTPATH_EN
    localparam bit FASTPATH = 1'b1;
`else
    localparam bit FASTPATH = 1'b0;
`endif

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    logic [7:0] o_q, o_r;
    logic       o_dbz, o_busy_seen, o_overlap, o_timeout;
    int         o_lat;

    seq_restoring_divider_if #(.WIDTH(WIDTH)) dif ();

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain integer division; zero divisor gives all ones and the dividend.
    task automatic push_expected(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        bit   fast;
        fast = FASTPATH && (b == 8'd0);
        if (b == 8'd0) begin
            e.q = 8'hFF;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        e.dbz  = fast;
        // Counted in falling edges from the start cycle: done appears after edge E_WIDTH.
        e.lat  = fast ? 1 : WIDTH + 1;
        e.busy = !fast;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int k;
        k = 1;
        o_busy_seen = 1'b0;
        while (dif.done !== 1'b1 && k <= 3 * WIDTH) begin
            o_busy_seen |= (dif.busy === 1'b1);
            @(negedge clk);
            k++;
        end
        o_timeout = (dif.done !== 1'b1);
        o_overlap = (dif.busy === 1'b1) && (dif.done === 1'b1);
        o_lat     = k;
        o_q       = dif.quotient;
        o_r       = dif.remainder;
        o_dbz     = dif.div_by_zero;
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        push_expected(a, b);
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = 8'($urandom);
        dif.divisor  = 8'($urandom);
        wait_done();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dif.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", dif.busy); else n_pass++;
        n_checks++; if (dif.done !== 1'b0) $display("FAIL rst_done: got %b want 0", dif.done); else n_pass++;
        n_checks++; if (dif.quotient !== 8'd0) $display("FAIL rst_quot: got %0d want 0", dif.quotient); else n_pass++;
        n_checks++; if (dif.remainder !== 8'd0) $display("FAIL rst_rem: got %0d want 0", dif.remainder); else n_pass++;
        n_checks++; if (dif.div_by_zero !== 1'b0) $display("FAIL rst_dbz: got %b want 0", dif.div_by_zero); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({dif.busy, dif.done} !== 2'b00) $display("FAIL post_rst_idle: got %b want 00", {dif.busy, dif.done}); else n_pass++;
    endtask

    task automatic test_basic();
        exp_t e;
        do_op(8'd100, 8'd7);
        e = sb.pop_front();
        n_checks++; if (o_timeout) $display("FAIL basic_done: got no done want done"); else n_pass++;
        n_checks++; if (o_lat !== e.lat) $display("FAIL basic_latency: got %0d want %0d", o_lat, e.lat); else n_pass++;
        n_checks++; if (o_q !== e.q) $display("FAIL basic_quot: got %0d want %0d", o_q, e.q); else n_pass++;
        n_checks++; if (o_r !== e.r) $display("FAIL basic_rem: got %0d want %0d", o_r, e.r); else n_pass++;
        n_checks++; if (o_dbz !== 1'b0) $display("FAIL basic_dbz: got %b want 0", o_dbz); else n_pass++;
        n_checks++; if (o_overlap) $display("FAIL basic_busy_done: got both high want exclusive"); else n_pass++;
        @(negedge clk);
        n_checks++; if (dif.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", dif.done); else n_pass++;
        n_checks++; if ({dif.quotient, dif.remainder} !== {e.q, e.r})
            $display("FAIL basic_hold: got %0d r %0d want %0d r %0d", dif.quotient, dif.remainder, e.q, e.r); else n_pass++;
    endtask

    task automatic test_boundaries();
        logic [7:0] as [4];
        logic [7:0] bs [4];
        exp_t e;
        as = '{8'd255, 8'd5, 8'd0, 8'd255};
        bs = '{8'd1, 8'd9, 8'd3, 8'd255};
        for (int i = 0; i < 4; i++) begin
            do_op(as[i], bs[i]);
            e = sb.pop_front();
            n_checks++;
            if (o_timeout || {o_q, o_r, o_dbz} !== {e.q, e.r, e.dbz})
                $display("FAIL bound_%0d_%0d: got %0d r %0d dbz %b want %0d r %0d dbz %b",
                         as[i], bs[i], o_q, o_r, o_dbz, e.q, e.r, e.dbz);
            else n_pass++;
            n_checks++; if (o_lat !== e.lat) $display("FAIL bound_lat_%0d: got %0d want %0d", i, o_lat, e.lat); else n_pass++;
        end
    endtask

    task automatic test_div_by_zero();
        exp_t e;
        do_op(8'd200, 8'd0);
        e = sb.pop_front();
        n_checks++; if (o_timeout) $display("FAIL dbz_done: got no done want done"); else n_pass++;
        n_checks++; if (o_lat !== e.lat) $display("FAIL dbz_latency: got %0d want %0d", o_lat, e.lat); else n_pass++;
        n_checks++; if ({o_q, o_r} !== {e.q, e.r}) $display("FAIL dbz_result: got %0d r %0d want %0d r %0d", o_q, o_r, e.q, e.r); else n_pass++;
        n_checks++; if (o_dbz !== e.dbz) $display("FAIL dbz_flag: got %b want %b", o_dbz, e.dbz); else n_pass++;
        n_checks++; if (o_busy_seen !== e.busy) $display("FAIL dbz_busy: got %b want %b", o_busy_seen, e.busy); else n_pass++;
        n_checks++; if (o_overlap) $display("FAIL dbz_busy_done: got both high want exclusive"); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 8'd50; dif.divisor = 8'd3;
        push_expected(8'd50, 8'd3);
        @(negedge clk);
        dif.start = 1'b0; dif.dividend = 8'($urandom); dif.divisor = 8'($urandom);
        repeat (2) @(negedge clk);
        // A request while busy must be dropped, not queued or restarted.
        dif.start = 1'b1; dif.dividend = 8'd9; dif.divisor = 8'd2;
        @(negedge clk);
        dif.start = 1'b0; dif.dividend = 8'($urandom); dif.divisor = 8'($urandom);
        wait_done();
        e = sb.pop_front();
        n_checks++;
        if (o_timeout || {o_q, o_r} !== {e.q, e.r})
            $display("FAIL b2b_first: got %0d r %0d want %0d r %0d", o_q, o_r, e.q, e.r);
        else n_pass++;
        dif.start = 1'b1; dif.dividend = 8'd9; dif.divisor = 8'd2;
        push_expected(8'd9, 8'd2);
        @(negedge clk);
        dif.start = 1'b0; dif.dividend = 8'($urandom); dif.divisor = 8'($urandom);
        wait_done();
        e = sb.pop_front();
        n_checks++;
        if (o_timeout || {o_q, o_r} !== {e.q, e.r})
            $display("FAIL b2b_second: got %0d r %0d want %0d r %0d", o_q, o_r, e.q, e.r);
        else n_pass++;
        n_checks++; if (o_lat !== e.lat) $display("FAIL b2b_latency: got %0d want %0d", o_lat, e.lat); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        logic seen_done;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 8'd77; dif.divisor = 8'd5;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero} !== 19'd0)
            $display("FAIL midrst_outputs: got busy %b done %b q %0d r %0d dbz %b want all 0",
                     dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (3 * WIDTH) begin
            @(negedge clk);
            seen_done |= (dif.done === 1'b1);
        end
        n_checks++; if (seen_done) $display("FAIL midrst_no_done: got done pulse want none"); else n_pass++;
        do_op(8'd77, 8'd5);
        e = sb.pop_front();
        n_checks++;
        if (o_timeout || {o_q, o_r, o_dbz} !== {e.q, e.r, e.dbz})
            $display("FAIL midrst_rerun: got %0d r %0d want %0d r %0d", o_q, o_r, e.q, e.r);
        else n_pass++;
        n_checks++; if (o_lat !== e.lat) $display("FAIL midrst_latency: got %0d want %0d", o_lat, e.lat); else n_pass++;
    endtask

    task automatic test_random_sweep();
        exp_t e;
        logic [7:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            do_op(a, b);
            e = sb.pop_front();
            n_checks++;
            if (o_timeout || o_lat !== e.lat || {o_q, o_r, o_dbz} !== {e.q, e.r, e.dbz})
                $display("FAIL sweep_model %0d/%0d: got %0d r %0d lat %0d want %0d r %0d lat %0d",
                         a, b, o_q, o_r, o_lat, e.q, e.r, e.lat);
            else n_pass++;
            n_checks++;
            if ((int'(o_q) * int'(b) + int'(o_r)) != int'(a) || o_r >= b)
                $display("FAIL sweep_identity %0d/%0d: got %0d r %0d want q*d+r==n and r<d", a, b, o_q, o_r);
            else n_pass++;
        end
    endtask

    initial begin
        dif.start    = 1'b0;
        dif.dividend = 8'd0;
        dif.divisor  = 8'd0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_by_zero();
        test_back_to_back();
        test_reset_midrun();
        test_random_sweep();
        n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Multi-cycle unsigned integer divider for the datapath. It is the inverse of the team's adder chain and is built on repeated trial subtraction with a WIDTH+1-bit partial remainder. It resolves one quotient bit per clock and uses a start/done handshake, so it sits beside the combinational adders as a shared arithmetic unit.

## Interface
- WIDTH, 8, operand, quotient and remainder width in bits (≥2)
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, captured on accepted start
- divisor  input  WIDTH  unsigned divisor, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- quotient  output  WIDTH  result, held until the next completion
- remainder  output  WIDTH  result, held until the next completion
- div_by_zero  output  1  flags the last completed operation; valid with and after done

Clocking: one clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, RUN. done is a registered pulse, not a state.
- IDLE, start=1:
  - Capture M=divisor, Q=dividend, A=0 (WIDTH+1 bits), count=WIDTH.
  - Go to RUN.
- RUN, each cycle:
  - Shift {A,Q} left by 1.
  - Compute T=A−{0,M} in WIDTH+1 bits.
  - If T[WIDTH]=1 (negative): keep A, set Q[0]=0.
  - Otherwise: A=T, Q[0]=1.
  - Decrement count.
- Last iteration (count 1→0):
  - Load quotient=Q and remainder=A[WIDTH-1:0].
  - Set done=1, busy=0, div_by_zero=0.
  - Return to IDLE.
- start is ignored in RUN. Inputs may change freely after capture.
- start in the same cycle as done=1 is accepted, so back-to-back operations are allowed.
- Reset, including mid-RUN: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. The operation in flight is discarded and no done is produced.

## Timing
- start accepted at edge E0 → busy=1 after E0. Iterations run on E1..E_WIDTH.
- done=1 and results valid in the cycle after E_WIDTH. This is a latency of WIDTH cycles after acceptance and one cycle of throughput gap to the next start.
- done is high for exactly one cycle. quotient, remainder and div_by_zero remain stable afterwards.
- busy is high from the cycle after E0 through the cycle before done. busy and done are never high together.

## Configuration
- Macro DIVIDER_DBZ_FASTPATH_EN.
- Defined: an accepted start with divisor==0 does not enter RUN.
  - At E0, load quotient=all ones, remainder=dividend, div_by_zero=1, done=1.
  - State stays IDLE and busy stays 0. Latency is 1 cycle.
- Undefined: a zero divisor runs the normal WIDTH-cycle loop.
  - The loop naturally yields quotient=all ones and remainder=dividend.
  - div_by_zero is tied to 0.

## Test plan
All scenarios use WIDTH=8.
- 100/7: start one cycle → done exactly 8 cycles after acceptance, quotient=14, remainder=2, div_by_zero=0.
- Boundaries: 255/1 → 255 r 0. 5/9 → 0 r 5. 0/3 → 0 r 0. 255/255 → 1 r 0.
- 200/0 with macro defined → done 1 cycle after acceptance, quotient=255, remainder=200, div_by_zero=1, busy never high. Without the macro → done after 8 cycles, same quotient and remainder, div_by_zero=0.
- Accept 50/3, then pulse start with 9/2 and change the operands while busy → 16 r 2 is reported and the second request is ignored. start during the done cycle with 9/2 → 4 r 1 follows 8 cycles later.
- Assert rst_n low for one cycle at iteration 4 of 77/5 → all outputs 0 immediately with no clock edge needed. No done pulse follows. A new 77/5 afterwards → 15 r 2.
- Random sweep of 1000 operand pairs against a reference model: quotient·divisor+remainder==dividend and remainder<divisor.
